seq_multiplier: RTL and testbench

//   Sequential radix-2 shift-add multiplier. It is the multiplication counterpart of the

---
 rtl/mult_pkg.sv | 29 ++
 rtl/mult_step.sv | 44 ++++
 rtl/seq_multiplier.sv | 188 ++++++++++++++++++
 tb/tb_seq_multiplier.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
//   Shared types and helpers for the sequential multiplier (and for the
//   divider sequencer, which uses the same counter sizing).
//
//   Contents:
//     mult_state_t  - FSM state encoding {IDLE, BUSY, DONE}
//     cnt_width()   - width of an iteration counter that must reach width-1
// ---------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // A counter that runs 0..width-1 needs $clog2(width) bits. Clamp to 1 so
    // a degenerate width never yields a zero-width vector.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mult_step.sv
// ---------------------------------------------------------------------------
// mult_step
//   One combinational shift-add iteration of the radix-2 multiplier.
//   If mplier[0] is set, mcand is added to acc. The add uses a ripple chain of
//   full adders, so the sum is WIDTH+1 bits wide including the carry. The
//   concatenation {sum, mplier} is then shifted right by one bit.
//
//   Ports:
//     acc         in   WIDTH   upper half of the running product
//     mplier      in   WIDTH   lower half / remaining multiplier bits
//     mcand       in   WIDTH   multiplicand
//     acc_next    out  WIDTH   acc after add and shift (carry enters the MSB)
//     mplier_next out  WIDTH   mplier after shift (sum LSB enters the MSB)
// ---------------------------------------------------------------------------
module mult_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mplier,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mplier_next
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    // When the current multiplier bit is 0, add zero so the ripple chain is
    // always present and the shift path stays the same.
    assign addend   = mplier[0] ? mcand : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fulladder
        assign sum[i]     = acc[i] ^ addend[i] ^ carry[i];
        assign carry[i+1] = (acc[i] & addend[i]) | (carry[i] & (acc[i] ^ addend[i]));
    end

    // Shift {carry, sum, mplier} right by one. The bit shifted out of
    // mplier[0] has already been used above and is dropped here.
    assign acc_next    = {carry[WIDTH], sum[WIDTH-1:1]};
    assign mplier_next = {sum[0], mplier[WIDTH-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//   Sequential radix-2 shift-add multiplier. The block performs one add/shift
//   iteration per clock. Every operation takes exactly WIDTH BUSY cycles.
//   Operands arrive over a valid/ready handshake. The 2*WIDTH product leaves
//   over a second valid/ready handshake.
//
//   Ports:
//     clk_i      in   1        clock, rising edge
//     rst_ni     in   1        asynchronous active-low reset
//     valid_i    in   1        operand pair valid
//     ready_o    out  1        operands accepted (high only in IDLE)
//     a_i        in   WIDTH    multiplicand
//     b_i        in   WIDTH    multiplier
//     valid_o    out  1        product valid (high only in DONE)
//     ready_i    in   1        consumer accepts product
//     product_o  out  2*WIDTH  a_i * b_i
//
//   Configuration macro:
//     SEQ_MULT_SIGNED_EN  defined     -> operands and product are two's complement
//                         not defined -> unsigned only, no sign logic built
// ---------------------------------------------------------------------------
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    mult_state_t state, state_next;

    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   mplier_next;
    logic [2*WIDTH-1:0] result_next;
    logic [WIDTH-1:0]   a_load;
    logic [WIDTH-1:0]   b_load;
    logic               accept;
    logic               last_step;

    assign accept    = valid_i && ready_o;
    assign last_step = (cnt == LAST_CNT);

    mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc         (acc),
        .mplier      (mplier),
        .mcand       (mcand),
        .acc_next    (acc_next),
        .mplier_next (mplier_next)
    );

`ifdef SEQ_MULT_SIGNED_EN
    logic neg;
    logic neg_load;

    // Prepare signed operands. The core always multiplies magnitudes.
    // -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits as an unsigned
    // WIDTH-bit value. The sign of the result is kept separately.
    always_comb begin
        a_load   = a_i[WIDTH-1] ? (~a_i + 1'b1) : a_i;
        b_load   = b_i[WIDTH-1] ? (~b_i + 1'b1) : b_i;
        neg_load = a_i[WIDTH-1] ^ b_i[WIDTH-1];
    end

    // Restore the sign on the final iteration's output, before it is
    // captured into the product register.
    always_comb begin
        result_next = {acc_next, mplier_next};
        if (neg) begin
            result_next = ~{acc_next, mplier_next} + 1'b1;
        end
    end

    // The sign flag is captured on the accept edge, together with the
    // operand magnitudes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            neg <= 1'b0;
        end else if (accept) begin
            neg <= neg_load;
        end
    end
`else
    // Unsigned build: operands go straight into the datapath.
    always_comb begin
        a_load      = a_i;
        b_load      = b_i;
        result_next = {acc_next, mplier_next};
    end
`endif

    // State register. Reset aborts any operation in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs. DONE always returns to IDLE
    // rather than straight to BUSY, so a new operation can never be
    // accepted in the same cycle the product leaves.
    always_comb begin
        state_next = state;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers. The accept edge loads the operands and clears the
    // accumulator. Each BUSY edge applies one shift-add step. The last BUSY
    // edge also captures the finished product, so product_o holds steady
    // through DONE and afterwards until the next result replaces it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= '0;
                        mcand  <= a_load;
                        mplier <= b_load;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mplier <= mplier_next;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        product_q <= result_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product_o = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//   Directed and randomised checks of seq_multiplier with WIDTH=8.
//   Signed expectations are used when SEQ_MULT_SIGNED_EN is defined.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

    localparam int WIDTH = 8;
    localparam int LATENCY = WIDTH;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               valid_i;
    logic               ready_o;
    logic [WIDTH-1:0]   a_i;
    logic [WIDTH-1:0]   b_i;
    logic               valid_o;
    logic               ready_i;
    logic [2*WIDTH-1:0] product_o;

    int checkCount = 0;
    int failCount  = 0;

    seq_multiplier #(
        .WIDTH (WIDTH)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .a_i       (a_i),
        .b_i       (b_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .product_o (product_o)
    );

    // Free-running 10 ns clock.
    always #5 clk_i = ~clk_i;

    // Single comparison point. A mismatch is counted and reported.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference product, used only for the random phase.
    function automatic logic [2*WIDTH-1:0] refProduct(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
`ifdef SEQ_MULT_SIGNED_EN
        logic signed [2*WIDTH-1:0] sa;
        logic signed [2*WIDTH-1:0] sb;
        sa = {{WIDTH{a[WIDTH-1]}}, a};
        sb = {{WIDTH{b[WIDTH-1]}}, b};
        return sa * sb;
`else
        logic [2*WIDTH-1:0] ua;
        logic [2*WIDTH-1:0] ub;
        ua = {{WIDTH{1'b0}}, a};
        ub = {{WIDTH{1'b0}}, b};
        return ua * ub;
`endif
    endfunction

    // Idle for a while, then present one operand pair at a negedge and hold
    // it through the accept edge. Afterwards the operands are scrambled,
    // because the DUT must not need them once they have been accepted.
    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input int idleCycles);
        int waits;
        valid_i = 1'b0;
        repeat (idleCycles) @(negedge clk_i);
        waits = 0;
        while (!ready_o && waits < 50) begin
            @(negedge clk_i);
            waits++;
        end
        checkOutput($sformatf("%s.ready_before_accept", tag), {31'd0, ready_o}, 32'd1);
        valid_i = 1'b1;
        a_i     = a;
        b_i     = b;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        a_i     = WIDTH'($urandom);
        b_i     = WIDTH'($urandom);
    endtask

    // Run one complete operation. The task checks latency, the product,
    // product stability and handshake levels over `stall` DONE cycles with
    // ready_i low and junk on valid_i, and finally the return to IDLE.
    task automatic runOp(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [2*WIDTH-1:0] expected,
                         input int stall, input int idleCycles);
        int n;
        applyStimulus(tag, a, b, idleCycles);
        n = 0;
        while (!valid_o && n < 40) begin
            @(posedge clk_i);
            n++;
            @(negedge clk_i);
        end
        checkOutput($sformatf("%s.latency", tag), n, LATENCY);
        checkOutput($sformatf("%s.product", tag), {16'd0, product_o}, {16'd0, expected});
        checkOutput($sformatf("%s.ready_in_done", tag), {31'd0, ready_o}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            valid_i = 1'b1;
            a_i     = WIDTH'($urandom);
            b_i     = WIDTH'($urandom);
            @(negedge clk_i);
            checkOutput($sformatf("%s.stall%0d.product", tag, i), {16'd0, product_o}, {16'd0, expected});
            checkOutput($sformatf("%s.stall%0d.valid", tag, i), {31'd0, valid_o}, 32'd1);
            checkOutput($sformatf("%s.stall%0d.ready", tag, i), {31'd0, ready_o}, 32'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        checkOutput($sformatf("%s.valid_after_take", tag), {31'd0, valid_o}, 32'd0);
        checkOutput($sformatf("%s.ready_after_take", tag), {31'd0, ready_o}, 32'd1);
    endtask

    // Directed sequence followed by the random phase.
    initial begin
        logic [WIDTH-1:0]   ra;
        logic [WIDTH-1:0]   rb;
        logic [2*WIDTH-1:0] exp255;

        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        a_i     = '0;
        b_i     = '0;

        #12;
        checkOutput("reset.ready", {31'd0, ready_o}, 32'd1);
        checkOutput("reset.valid", {31'd0, valid_o}, 32'd0);
        checkOutput("reset.product", {16'd0, product_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Basic operation, a zero operand, and the largest unsigned operands.
        // In the signed build 0xFF is -1, so 0xFF * 0xFF = 1.
`ifdef SEQ_MULT_SIGNED_EN
        exp255 = 16'h0001;
`else
        exp255 = 16'hFE01;
`endif
        runOp("op13x11", 8'd13, 8'd11, 16'd143, 0, 0);
        runOp("op255x255", 8'hFF, 8'hFF, exp255, 0, 0);
        runOp("op0x200", 8'd0, 8'd200, 16'd0, 0, 1);

        // The consumer stalls for five cycles while DONE.
        runOp("stall12x10", 8'd12, 8'd10, 16'd120, 5, 0);

        // Reset pulsed in the middle of BUSY: outputs clear immediately and
        // the aborted product never appears.
        applyStimulus("abort", 8'd200, 8'd100, 0);
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        checkOutput("abort.ready", {31'd0, ready_o}, 32'd1);
        checkOutput("abort.valid", {31'd0, valid_o}, 32'd0);
        checkOutput("abort.product", {16'd0, product_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            checkOutput($sformatf("abort.quiet%0d", i), {31'd0, valid_o}, 32'd0);
        end
        runOp("op3x7", 8'd3, 8'd7, 16'd21, 0, 0);

`ifdef SEQ_MULT_SIGNED_EN
        runOp("sgn_m128xm128", 8'h80, 8'h80, 16'h4000, 0, 0);
        runOp("sgn_m5x7", 8'hFB, 8'd7, 16'hFFDD, 0, 0);
        runOp("sgn_127xm1", 8'h7F, 8'hFF, 16'hFF81, 0, 0);
`endif

        // Random back-to-back operations with random idle and stall gaps.
        for (int k = 0; k < 300; k++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            runOp($sformatf("rand%0d", k), ra, rb, refProduct(ra, rb),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
